div_unit: RTL and testbench

DIV_UNIT -- requirements
Module: div_unit

---
 rtl/div_unit.sv | 153 +++++++++++++++
 tb/tb_div_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 restoring divider, RISC-V DIV/DIVU/REM/REMU
`timescale 1ns/1ps
module div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_op,
  input  logic [XLEN-1:0] in_a,
  input  logic [XLEN-1:0] in_b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result
);

  localparam int CW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [XLEN:0]   r_rem;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_div;
  logic [CW-1:0]   r_cnt;
  logic            r_is_rem;
  logic            r_neg_q;
  logic            r_neg_r;
  logic [XLEN-1:0] r_result;

  // Request decode, valid only while IDLE
  logic            w_signed;
  logic            w_div_zero;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;

  assign w_signed   = ~in_op[0];
  assign w_div_zero = (in_b == '0);
  assign w_ovf      = w_signed && (in_a == MIN_VAL) && (in_b == '1);
  assign w_special  = w_div_zero || w_ovf;
  assign w_a_neg    = w_signed & in_a[XLEN-1];
  assign w_b_neg    = w_signed & in_b[XLEN-1];
  assign w_a_mag    = w_a_neg ? (~in_a + 1'b1) : in_a;
  assign w_b_mag    = w_b_neg ? (~in_b + 1'b1) : in_b;

  always_comb begin
    w_special_res = '0;
    if (w_div_zero) begin
      w_special_res = in_op[1] ? in_a : '1;
    end else if (w_ovf) begin
      w_special_res = in_op[1] ? '0 : in_a;
    end
  end

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor
  logic [XLEN+1:0] w_rem_shift;
  logic [XLEN+1:0] w_diff;
  logic            w_q_bit;
  logic [XLEN:0]   w_rem_nxt;
  logic [XLEN-1:0] w_quo_nxt;
  logic            w_last;
  logic [XLEN-1:0] w_q_fix;
  logic [XLEN-1:0] w_r_fix;
  logic [XLEN-1:0] w_final;

  assign w_rem_shift = {r_rem, r_quo[XLEN-1]};
  assign w_diff      = w_rem_shift - {2'b00, r_div};
  assign w_q_bit     = ~w_diff[XLEN+1];
  assign w_rem_nxt   = w_q_bit ? w_diff[XLEN:0] : w_rem_shift[XLEN:0];
  assign w_quo_nxt   = {r_quo[XLEN-2:0], w_q_bit};
  assign w_last      = (r_cnt == CW'(XLEN - 1));
  assign w_q_fix     = r_neg_q ? (~w_quo_nxt + 1'b1) : w_quo_nxt;
  assign w_r_fix     = r_neg_r ? (~w_rem_nxt[XLEN-1:0] + 1'b1) : w_rem_nxt[XLEN-1:0];
  assign w_final     = r_is_rem ? w_r_fix : w_q_fix;

  assign in_ready   = (r_state == S_IDLE);
  assign out_valid  = (r_state == S_DONE);
  assign out_result = r_result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) w_state_nxt = w_special ? S_DONE : S_BUSY;
        S_BUSY: if (w_last) w_state_nxt = S_DONE;
        S_DONE: if (out_ready) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_cnt    <= '0;
      r_is_rem <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= '0;
    end else if (flush) begin
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_is_rem <= in_op[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_rem    <= '0;
            r_quo    <= w_a_mag;
            r_div    <= w_b_mag;
            r_cnt    <= '0;
            if (w_special) r_result <= w_special_res;
          end
        end
        S_BUSY: begin
          r_rem <= w_rem_nxt;
          r_quo <= w_quo_nxt;
          r_cnt <= r_cnt + CW'(1);
          if (w_last) r_result <= w_final;
        end
        S_DONE: begin
          if (out_ready) r_result <= '0;
        end
        default: r_result <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard bench for div_unit (XLEN=32)
`timescale 1ns/1ps
module tb_div_unit;

  localparam int XLEN = 32;
  localparam logic [31:0] MIN_VAL = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'd0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] sb_q[$];

  div_unit #(.XLEN(XLEN)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_a       (in_a),
    .in_b       (in_b),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] golden(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic ovf;
    ovf = (a == MIN_VAL) && (b == 32'hFFFF_FFFF);
    case (op)
      2'd0: golden = (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'($signed(a) / $signed(b)));
      2'd1: golden = (b == 0) ? 32'hFFFF_FFFF : a / b;
      2'd2: golden = (b == 0) ? a : (ovf ? 32'd0 : 32'($signed(a) % $signed(b)));
      default: golden = (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    return (b == 0) || (!op[0] && a == MIN_VAL && b == 32'hFFFF_FFFF);
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return MIN_VAL;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  // Called just after the accept edge; waits for the result, applies backpressure, consumes it
  task automatic finish_op(input string tag, input int exp_lat, input int hold);
    int n;
    logic [31:0] exp;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check({tag, "_valid"}, 64'(out_valid), 64'd1);
    exp = (sb_q.size() > 0) ? sb_q[0] : 32'hDEAD_BEEF;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold"}, {30'd0, out_valid, in_ready, out_result}, {30'd0, 1'b1, 1'b0, exp});
    end
    @(negedge clk);
    out_ready = 1'b1;
    if (sb_q.size() > 0) exp = sb_q.pop_front();
    check(tag, 64'(out_result), 64'(exp));
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_release"}, {30'd0, out_valid, in_ready, out_result}, {30'd0, 1'b0, 1'b1, 32'd0});
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input string tag, input logic [31:0] exp);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, 64'(in_ready), 64'd1);
    sb_q.push_back(exp);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_op    = 2'($urandom);
    in_a     = $urandom;
    in_b     = $urandom;
    finish_op(tag, is_special(op, a, b) ? 0 : XLEN, hold);
  endtask

  initial begin
    logic seen;
    logic [1:0] op;
    logic [31:0] a, b;

    #2;
    check("reset_state", {30'd0, in_ready, out_valid, out_result}, {30'd0, 1'b1, 1'b0, 32'd0});
    @(negedge clk);
    rst = 1'b0;

    run_op(2'd0, 32'hFFFF_FFF9, 32'd2, 0, "div_m7_2", 32'hFFFF_FFFD);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 0, "rem_m7_2", 32'hFFFF_FFFF);
    run_op(2'd1, MIN_VAL, 32'd0, 0, "divu_by0", 32'hFFFF_FFFF);
    run_op(2'd3, MIN_VAL, 32'd0, 0, "remu_by0", MIN_VAL);
    run_op(2'd0, 32'd5, 32'd0, 0, "div_by0", 32'hFFFF_FFFF);
    run_op(2'd0, MIN_VAL, 32'hFFFF_FFFF, 0, "div_ovf", MIN_VAL);
    run_op(2'd2, MIN_VAL, 32'hFFFF_FFFF, 0, "rem_ovf", 32'd0);
    run_op(2'd1, 32'd100, 32'd7, 5, "divu_bp", 32'd14);
    run_op(2'd2, 32'd7, 32'hFFFF_FFFE, 1, "rem_7_m2", 32'd1);
    run_op(2'd0, 32'd7, 32'hFFFF_FFFE, 0, "div_7_m2", 32'hFFFF_FFFD);

    // Flush on the tenth iteration edge
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'd1; in_a = 32'd100; in_b = 32'd7;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_idle", {30'd0, in_ready, out_valid, out_result}, {30'd0, 1'b1, 1'b0, 32'd0});
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    check("flush_no_valid", 64'(seen), 64'd0);
    run_op(2'd3, 32'd100, 32'd7, 0, "remu_after_flush", 32'd2);

    // Flush beats accept in IDLE
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; in_op = 2'd1; in_a = 32'd100; in_b = 32'd0;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_blocks_accept", {62'd0, in_ready, out_valid}, {62'd0, 1'b1, 1'b0});

    // Asynchronous reset mid-BUSY drops the operation
    @(negedge clk);
    in_valid = 1'b1; in_op = 2'd0; in_a = 32'd1000; in_b = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1 check("rst_async", {30'd0, in_ready, out_valid, out_result}, {30'd0, 1'b1, 1'b0, 32'd0});
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= out_valid;
    end
    check("rst_no_result", 64'(seen), 64'd0);

    // Accept on the first edge after reset release
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; in_op = 2'd1; in_a = 32'd1000; in_b = 32'd3;
    sb_q.push_back(32'd333);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("first_edge_accept", 64'(in_ready), 64'd0);
    finish_op("divu_post_rst", XLEN, 0);

    for (int i = 0; i < 1200; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick_operand();
      b  = pick_operand();
      run_op(op, a, b, $urandom_range(0, 3), "rand", golden(op, a, b));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
